// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: control-unit enables, memory/regfile inputs and decoded
// fetch-stage outputs of the multi-cycle MIPS fetch unit.
interface pc_fetch_unit_if;
    logic        PCWre;
    logic        IRWre;
    logic [1:0]  PCSrc;
    logic [31:0] instr_in;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm16;
    logic        halted;
    logic        misalign;
    logic [31:0] retired;

    modport master (
        output PCWre, IRWre, PCSrc, instr_in, rs_data,
        input  pc, pc_plus4, ir, opcode, func, rs, rt, rd, sa,
        input  imm16, halted, misalign, retired
    );

    modport slave (
        input  PCWre, IRWre, PCSrc, instr_in, rs_data,
        output pc, pc_plus4, ir, opcode, func, rs, rt, rd, sa,
        output imm16, halted, misalign, retired
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC, IR and PC+4 registers of the multi-cycle MIPS fetch stage,
// next-PC select, IR field decode, halt/misalign status and retire count.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_unit_if.slave f
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ret_q, ret_d;
    logic        mis_q, mis_d;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    always_comb begin
        next_pc = pc_q + 32'd4;
        unique case (f.PCSrc)
            2'b00: next_pc = pc_q + 32'd4;
            2'b01: next_pc = pc4_q + br_off;
            2'b10: next_pc = {f.rs_data[31:2], 2'b00};
            2'b11: next_pc = {pc4_q[31:28], ir_q[25:0], 2'b00};
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        pc4_d = pc4_q;
        ir_d  = ir_q;
        ret_d = ret_q;
        mis_d = mis_q;
        if (f.PCWre) begin
            pc_d  = next_pc;
            ret_d = ret_q + 32'd1;
            if (f.PCSrc == 2'b10 && f.rs_data[1:0] != 2'b00)
                mis_d = 1'b1;
        end
        // IR and PC+4 always capture from the pre-update pc
        if (f.IRWre) begin
            ir_d  = f.instr_in;
            pc4_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_PC;
            pc4_q <= RESET_PC + 32'd4;
            ir_q  <= 32'h0;
            ret_q <= 32'h0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            pc4_q <= pc4_d;
            ir_q  <= ir_d;
            ret_q <= ret_d;
            mis_q <= mis_d;
        end
    end

    assign f.pc       = pc_q;
    assign f.pc_plus4 = pc4_q;
    assign f.ir       = ir_q;
    assign f.opcode   = ir_q[31:26];
    assign f.func     = ir_q[5:0];
    assign f.rs       = ir_q[25:21];
    assign f.rt       = ir_q[20:16];
    assign f.rd       = ir_q[15:11];
    assign f.sa       = ir_q[10:6];
    assign f.imm16    = ir_q[15:0];
    assign f.halted   = (ir_q[31:26] == HALT_OP);
    assign f.misalign = mis_q;
    assign f.retired  = ret_q;
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the multi-cycle 19-instruction MIPS core. Holds the PC, the instruction register (IR) and the registered PC+4. Selects the next PC from the control unit's PCSrc/PCWre, latches the fetched word under IRWre, and decodes the IR fields that drive the control unit and register file.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 00.
- HALT_OP, 6'b111111: opcode that raises `halted`.

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- PCWre  in  1  PC write enable from control unit
- IRWre  in  1  IR write enable from control unit
- PCSrc  in  2  next-PC select: 00 pc+4, 01 branch target, 10 rs_data (jr), 11 jump target
- instr_in  in  32  instruction memory read data at address `pc` (combinational memory)
- rs_data  in  32  register-file read port 1, used as the jr target
- pc  out  32  current PC and instruction memory address
- pc_plus4  out  32  registered PC+4 of the instruction in IR; jal link value
- ir  out  32  instruction register
- opcode, func  out  6 each  ir[31:26], ir[5:0]
- rs, rt, rd, sa  out  5 each  ir[25:21], ir[20:16], ir[15:11], ir[10:6]
- imm16  out  16  ir[15:0]
- halted  out  1  IR opcode equals HALT_OP
- misalign  out  1  sticky: a jr target had nonzero bits [1:0]
- retired  out  32  count of PC updates (instructions completed)

## Operation
- Next-PC mux is combinational, computed from the IR and the current pc_plus4:
  - 00: pc + 4
  - 01: pc_plus4 + (sign-extended imm16 << 2)
  - 10: {rs_data[31:2], 2'b00}
  - 11: {pc_plus4[31:28], ir[25:0], 2'b00}
- All additions are 32-bit modulo 2^32. Wrap-around is silent: 32'hFFFF_FFFC + 4 = 0. Negative offsets wrap the same way.
- PCWre=1: pc ← next-PC and retired ← retired + 1 (wraps at 2^32). PCWre=0: pc and retired hold.
- IRWre=1: ir ← instr_in and pc_plus4 ← pc + 4. IRWre=0: both hold.
- When PCWre and IRWre are both 1 in the same cycle:
  - ir and pc_plus4 capture from the old pc.
  - pc takes the new value.
  - The new instruction is captured at the end of the following IF cycle.
- PCSrc=10 with rs_data[1:0] ≠ 00 and PCWre=1 sets misalign. misalign is cleared only by reset. PCSrc=10 with PCWre=0 never sets it.
- `halted` is combinational from ir. Halt is enforced by the control unit holding PCWre=0; this block only reports it.
- Field outputs are pure slices of ir; no other state.

## Timing
- Reset (rst=0, asynchronous, effective immediately regardless of clk):
  - pc = RESET_PC, pc_plus4 = RESET_PC + 4
  - ir = 0 (decodes as sll $0,$0,0 nop)
  - retired = 0, misalign = 0, halted = 0
- Reset asserted mid-instruction discards all in-flight state. The first edge after rst rises fetches from RESET_PC.
- Latency:
  - next-PC to pc: 1 edge
  - instr_in to ir and field outputs: 1 edge
  - ir to halted: 0 cycles (combinational)
- Branch and jump targets use the IR and pc_plus4 values present in the cycle PCWre is high. The control unit asserts PCWre only in the final state of an instruction, so those values belong to the executing instruction.
- No handshake; the block is purely enable-driven. Inputs must be stable before the rising edge. PCWre changes on the falling edge upstream, which gives half a cycle of setup.

## Test plan
- Reset and sequential fetch:
  - Stimulus: rst pulse low mid-cycle with clk stopped; then PCSrc=00, PCWre=1 for 3 edges.
  - Required: immediately pc=0, ir=0, retired=0; after the edges pc=0x0C, retired=3.
- Branch:
  - Stimulus: ir=beq with imm16=0xFFFE, pc_plus4=0x14, PCSrc=01, PCWre=1.
  - Required: pc=0x0C.
  - Stimulus: repeat with imm16=0x0003.
  - Required: pc=0x20.
- Jump, jr and misalign:
  - Stimulus: ir=j with target 0x0000040, pc_plus4=0x1000_0008, PCSrc=11.
  - Required: pc=0x1000_0100.
  - Stimulus: PCSrc=10, rs_data=0x0000_0203.
  - Required: pc=0x200, misalign=1; misalign stays 1 until reset.
- Enable gating:
  - Stimulus: PCWre=0, IRWre=0 for 4 edges while instr_in and PCSrc toggle.
  - Required: pc, ir, pc_plus4 and retired unchanged.
- Simultaneous PCWre/IRWre:
  - Stimulus: pc=0x08, instr_in=0x2401_0005, both enables high, PCSrc=00.
  - Required: ir=0x2401_0005, pc_plus4=0x0C, pc=0x0C after one edge.
- Halt and wrap:
  - Stimulus: instr_in=0xFC00_0000 latched into ir.
  - Required: halted=1 in the same cycle ir updates.
  - Stimulus: pc=0xFFFF_FFFC, PCSrc=00, PCWre=1.
  - Required: pc=0x0000_0000.
